// File: rtl/alu_issue_station.sv
// ALU reservation station: buffers ALU-class ops, snoops two CDB ports,
// and issues the lowest-index ready entry as registered ALU inputs.
//
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (low = freeze),
//   flush_in (sync clear).
//   in_*  : dispatch request with operands, producer tags and RoB tag.
//   rs_full : every entry is busy.
//   cdb0_* / cdb1_* : result broadcasts (ALU / LSB).
//   alu_* : registered issue outputs; alu_op == 0 means no issue.
module alu_issue_station #(
   parameter int RS_SIZE = 8,
   parameter int RS_W    = 3,
   parameter int ROB_W   = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             flush_in,
   input  logic             in_valid,
   input  logic [5:0]       in_op,
   input  logic [31:0]      in_vj,
   input  logic [ROB_W-1:0] in_qj,
   input  logic             in_qj_busy,
   input  logic [31:0]      in_vk,
   input  logic [ROB_W-1:0] in_qk,
   input  logic             in_qk_busy,
   input  logic [ROB_W-1:0] in_robid,
   output logic             rs_full,
   input  logic             cdb0_valid,
   input  logic [ROB_W-1:0] cdb0_robid,
   input  logic [31:0]      cdb0_value,
   input  logic             cdb1_valid,
   input  logic [ROB_W-1:0] cdb1_robid,
   input  logic [31:0]      cdb1_value,
   output logic [31:0]      alu_rs1,
   output logic [31:0]      alu_rs2,
   output logic [5:0]       alu_op,
   output logic [ROB_W-1:0] alu_robid
);

   logic [RS_SIZE-1:0]            busy_q, busy_d;
   logic [RS_SIZE-1:0][5:0]       op_q, op_d;
   logic [RS_SIZE-1:0][31:0]      vj_q, vj_d;
   logic [RS_SIZE-1:0][31:0]      vk_q, vk_d;
   logic [RS_SIZE-1:0][ROB_W-1:0] qj_q, qj_d;
   logic [RS_SIZE-1:0][ROB_W-1:0] qk_q, qk_d;
   logic [RS_SIZE-1:0]            qjb_q, qjb_d;
   logic [RS_SIZE-1:0]            qkb_q, qkb_d;
   logic [RS_SIZE-1:0][ROB_W-1:0] robid_q, robid_d;

   logic [31:0]      alu_rs1_q, alu_rs1_d;
   logic [31:0]      alu_rs2_q, alu_rs2_d;
   logic [5:0]       alu_op_q, alu_op_d;
   logic [ROB_W-1:0] alu_robid_q, alu_robid_d;

   logic            iss_found;
   logic            free_found;
   logic [RS_W-1:0] free_idx;

   assign rs_full   = &busy_q;
   assign alu_rs1   = alu_rs1_q;
   assign alu_rs2   = alu_rs2_q;
   assign alu_op    = alu_op_q;
   assign alu_robid = alu_robid_q;

   always_comb begin
      busy_d      = busy_q;
      op_d        = op_q;
      vj_d        = vj_q;
      vk_d        = vk_q;
      qj_d        = qj_q;
      qk_d        = qk_q;
      qjb_d       = qjb_q;
      qkb_d       = qkb_q;
      robid_d     = robid_q;
      alu_rs1_d   = alu_rs1_q;
      alu_rs2_d   = alu_rs2_q;
      alu_robid_d = alu_robid_q;
      alu_op_d    = '0;
      iss_found   = 1'b0;
      free_found  = 1'b0;
      free_idx    = '0;

      if (flush_in) begin
         busy_d = '0;
      end else if (rdy_in) begin
         // Issue: readiness looks only at registered state
         for (int i = 0; i < RS_SIZE; i++) begin
            if (!iss_found && busy_q[i] && !qjb_q[i] && !qkb_q[i]) begin
               iss_found   = 1'b1;
               alu_rs1_d   = vj_q[i];
               alu_rs2_d   = vk_q[i];
               alu_op_d    = op_q[i];
               alu_robid_d = robid_q[i];
               busy_d[i]   = 1'b0;
            end
         end

         // Wakeup: port 0 takes precedence on a tag clash
         for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i] && qjb_q[i]) begin
               if (cdb0_valid && cdb0_robid == qj_q[i]) begin
                  vj_d[i]  = cdb0_value;
                  qjb_d[i] = 1'b0;
               end else if (cdb1_valid && cdb1_robid == qj_q[i]) begin
                  vj_d[i]  = cdb1_value;
                  qjb_d[i] = 1'b0;
               end
            end
            if (busy_q[i] && qkb_q[i]) begin
               if (cdb0_valid && cdb0_robid == qk_q[i]) begin
                  vk_d[i]  = cdb0_value;
                  qkb_d[i] = 1'b0;
               end else if (cdb1_valid && cdb1_robid == qk_q[i]) begin
                  vk_d[i]  = cdb1_value;
                  qkb_d[i] = 1'b0;
               end
            end
         end

         // Free slot comes from pre-edge busy, so a slot freed by
         // this edge's issue is only reusable next cycle
         for (int i = 0; i < RS_SIZE; i++) begin
            if (!free_found && !busy_q[i]) begin
               free_found = 1'b1;
               free_idx   = RS_W'(i);
            end
         end

         if (in_valid && free_found) begin
            busy_d[free_idx]  = 1'b1;
            op_d[free_idx]    = in_op;
            robid_d[free_idx] = in_robid;
            vj_d[free_idx]    = in_vj;
            qj_d[free_idx]    = in_qj;
            qjb_d[free_idx]   = in_qj_busy;
            vk_d[free_idx]    = in_vk;
            qk_d[free_idx]    = in_qk;
            qkb_d[free_idx]   = in_qk_busy;
            // Same-edge bypass from a broadcast of the awaited tag
            if (in_qj_busy) begin
               if (cdb0_valid && cdb0_robid == in_qj) begin
                  vj_d[free_idx]  = cdb0_value;
                  qjb_d[free_idx] = 1'b0;
               end else if (cdb1_valid && cdb1_robid == in_qj) begin
                  vj_d[free_idx]  = cdb1_value;
                  qjb_d[free_idx] = 1'b0;
               end
            end
            if (in_qk_busy) begin
               if (cdb0_valid && cdb0_robid == in_qk) begin
                  vk_d[free_idx]  = cdb0_value;
                  qkb_d[free_idx] = 1'b0;
               end else if (cdb1_valid && cdb1_robid == in_qk) begin
                  vk_d[free_idx]  = cdb1_value;
                  qkb_d[free_idx] = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         busy_q      <= '0;
         op_q        <= '0;
         vj_q        <= '0;
         vk_q        <= '0;
         qj_q        <= '0;
         qk_q        <= '0;
         qjb_q       <= '0;
         qkb_q       <= '0;
         robid_q     <= '0;
         alu_rs1_q   <= '0;
         alu_rs2_q   <= '0;
         alu_op_q    <= '0;
         alu_robid_q <= '0;
      end else begin
         busy_q      <= busy_d;
         op_q        <= op_d;
         vj_q        <= vj_d;
         vk_q        <= vk_d;
         qj_q        <= qj_d;
         qk_q        <= qk_d;
         qjb_q       <= qjb_d;
         qkb_q       <= qkb_d;
         robid_q     <= robid_d;
         alu_rs1_q   <= alu_rs1_d;
         alu_rs2_q   <= alu_rs2_d;
         alu_op_q    <= alu_op_d;
         alu_robid_q <= alu_robid_d;
      end
   end

endmodule

// File: tb/tb_alu_issue_station.sv
// Directed bench for alu_issue_station: dispatch, wakeup, bypass,
// fill/drop, issue priority, freeze, flush and async reset.
module tb_alu_issue_station;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        flush_in;
   logic        in_valid;
   logic [5:0]  in_op;
   logic [31:0] in_vj;
   logic [3:0]  in_qj;
   logic        in_qj_busy;
   logic [31:0] in_vk;
   logic [3:0]  in_qk;
   logic        in_qk_busy;
   logic [3:0]  in_robid;
   logic        rs_full;
   logic        cdb0_valid;
   logic [3:0]  cdb0_robid;
   logic [31:0] cdb0_value;
   logic        cdb1_valid;
   logic [3:0]  cdb1_robid;
   logic [31:0] cdb1_value;
   logic [31:0] alu_rs1;
   logic [31:0] alu_rs2;
   logic [5:0]  alu_op;
   logic [3:0]  alu_robid;

   int total = 0;
   int bad   = 0;

   always #5 clk_in = ~clk_in;

   alu_issue_station dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .flush_in(flush_in), .in_valid(in_valid), .in_op(in_op),
      .in_vj(in_vj), .in_qj(in_qj), .in_qj_busy(in_qj_busy),
      .in_vk(in_vk), .in_qk(in_qk), .in_qk_busy(in_qk_busy),
      .in_robid(in_robid), .rs_full(rs_full),
      .cdb0_valid(cdb0_valid), .cdb0_robid(cdb0_robid),
      .cdb0_value(cdb0_value), .cdb1_valid(cdb1_valid),
      .cdb1_robid(cdb1_robid), .cdb1_value(cdb1_value),
      .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_op(alu_op),
      .alu_robid(alu_robid)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle;
      in_valid   = 1'b0;
      in_qj_busy = 1'b0;
      in_qk_busy = 1'b0;
      cdb0_valid = 1'b0;
      cdb1_valid = 1'b0;
      flush_in   = 1'b0;
   endtask

   task automatic disp(input logic [5:0] op, input logic [31:0] vj,
                       input logic qjb, input logic [3:0] qj,
                       input logic [31:0] vk, input logic qkb,
                       input logic [3:0] qk, input logic [3:0] rob);
      in_valid   = 1'b1;
      in_op      = op;
      in_vj      = vj;
      in_qj_busy = qjb;
      in_qj      = qj;
      in_vk      = vk;
      in_qk_busy = qkb;
      in_qk      = qk;
      in_robid   = rob;
   endtask

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1;
      in_op = '0; in_vj = '0; in_qj = '0; in_vk = '0; in_qk = '0;
      in_robid = '0; cdb0_robid = '0; cdb0_value = '0;
      cdb1_robid = '0; cdb1_value = '0;
      idle();
      #12;
      chk("rst_op", {26'd0, alu_op}, 32'd0);
      chk("rst_rs1", alu_rs1, 32'd0);
      chk("rst_rob", {28'd0, alu_robid}, 32'd0);
      chk("rst_full", {31'd0, rs_full}, 32'd0);
      rst_in = 1'b0;
      tick();

      // both operands ready: issue one cycle after dispatch
      disp(6'd1, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd2);
      tick(); idle();
      chk("addi_e0", {26'd0, alu_op}, 32'd0);
      tick();
      chk("addi_op", {26'd0, alu_op}, 32'd1);
      chk("addi_rs1", alu_rs1, 32'd5);
      chk("addi_rs2", alu_rs2, 32'd7);
      chk("addi_rob", {28'd0, alu_robid}, 32'd2);
      tick();
      chk("addi_gone", {26'd0, alu_op}, 32'd0);
      chk("addi_hold", alu_rs1, 32'd5);

      // qj pending, woken by cdb1 two cycles later
      disp(6'd2, 32'd0, 1'b1, 4'd3, 32'd1, 1'b0, 4'd0, 4'd5);
      tick(); idle();
      tick(); tick();
      chk("add_wait", {26'd0, alu_op}, 32'd0);
      cdb1_valid = 1'b1; cdb1_robid = 4'd3; cdb1_value = 32'h10;
      tick(); idle();
      chk("add_wake", {26'd0, alu_op}, 32'd0);
      tick();
      chk("add_op", {26'd0, alu_op}, 32'd2);
      chk("add_rs1", alu_rs1, 32'h10);
      chk("add_rs2", alu_rs2, 32'd1);
      chk("add_rob", {28'd0, alu_robid}, 32'd5);

      // same-edge bypass of qk from cdb0
      disp(6'd3, 32'd3, 1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 4'd6);
      cdb0_valid = 1'b1; cdb0_robid = 4'd4; cdb0_value = 32'd9;
      tick(); idle();
      chk("byp_e0", {26'd0, alu_op}, 32'd0);
      tick();
      chk("byp_op", {26'd0, alu_op}, 32'd3);
      chk("byp_rs1", alu_rs1, 32'd3);
      chk("byp_rs2", alu_rs2, 32'd9);

      // freeze: dispatch ignored while !rdy_in
      rdy_in = 1'b0;
      disp(6'd5, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd1);
      tick(); idle(); rdy_in = 1'b1;
      chk("frz_op", {26'd0, alu_op}, 32'd0);
      tick();
      chk("frz_nodisp", {26'd0, alu_op}, 32'd0);
      // freeze holds a ready entry back until rdy_in returns
      disp(6'd5, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd1);
      tick(); idle(); rdy_in = 1'b0;
      tick(); rdy_in = 1'b1;
      chk("frz_hold", {26'd0, alu_op}, 32'd0);
      tick();
      chk("frz_rel", {26'd0, alu_op}, 32'd5);
      chk("frz_rob", {28'd0, alu_robid}, 32'd1);
      tick();

      // fill all 8 with qj pending on tags 8..15
      for (int i = 0; i < 8; i++) begin
         chk("fill_nf", {31'd0, rs_full}, 32'd0);
         disp(6'd4, 32'd0, 1'b1, 4'(8 + i), 32'(i), 1'b0, 4'd0, 4'(i));
         tick();
      end
      idle();
      chk("full", {31'd0, rs_full}, 32'd1);
      disp(6'd7, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd15);
      tick(); idle();
      tick();
      chk("drop_op", {26'd0, alu_op}, 32'd0);
      chk("drop_full", {31'd0, rs_full}, 32'd1);
      cdb1_valid = 1'b1; cdb1_robid = 4'd13; cdb1_value = 32'h55;
      tick(); idle();
      chk("w5_full", {31'd0, rs_full}, 32'd1);
      tick();
      chk("w5_op", {26'd0, alu_op}, 32'd4);
      chk("w5_rob", {28'd0, alu_robid}, 32'd5);
      chk("w5_rs1", alu_rs1, 32'h55);
      chk("w5_rs2", alu_rs2, 32'd5);
      chk("w5_nf", {31'd0, rs_full}, 32'd0);

      // async reset between edges with 7 busy entries
      #2;
      rst_in = 1'b1;
      #1;
      chk("arst_op", {26'd0, alu_op}, 32'd0);
      chk("arst_full", {31'd0, rs_full}, 32'd0);
      chk("arst_rs1", alu_rs1, 32'd0);
      rst_in = 1'b0;
      cdb0_valid = 1'b1; cdb0_robid = 4'd8; cdb0_value = 32'd1;
      tick(); idle();
      tick();
      chk("arst_empty", {26'd0, alu_op}, 32'd0);

      // priority: idx1 and idx6 ready together
      for (int i = 0; i < 7; i++) begin
         disp(6'd6, 32'd0, 1'b1, 4'(8 + i), 32'(i), 1'b0, 4'd0, 4'(i));
         tick();
      end
      idle();
      cdb0_valid = 1'b1; cdb0_robid = 4'd9; cdb0_value = 32'hA1;
      cdb1_valid = 1'b1; cdb1_robid = 4'd14; cdb1_value = 32'hB6;
      tick(); idle();
      tick();
      chk("pri1_rob", {28'd0, alu_robid}, 32'd1);
      chk("pri1_rs1", alu_rs1, 32'hA1);
      tick();
      chk("pri6_op", {26'd0, alu_op}, 32'd6);
      chk("pri6_rob", {28'd0, alu_robid}, 32'd6);
      chk("pri6_rs1", alu_rs1, 32'hB6);
      tick();
      chk("pri_none", {26'd0, alu_op}, 32'd0);

      // flush at the edge a ready entry would issue
      disp(6'd7, 32'd2, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 4'd7);
      tick(); idle();
      flush_in = 1'b1;
      disp(6'd8, 32'd2, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 4'd9);
      cdb0_valid = 1'b1; cdb0_robid = 4'd8; cdb0_value = 32'd1;
      tick(); idle();
      chk("fl_op", {26'd0, alu_op}, 32'd0);
      chk("fl_full", {31'd0, rs_full}, 32'd0);
      tick();
      chk("fl_nodisp", {26'd0, alu_op}, 32'd0);
      cdb0_valid = 1'b1; cdb0_robid = 4'd10; cdb0_value = 32'd1;
      cdb1_valid = 1'b1; cdb1_robid = 4'd11; cdb1_value = 32'd1;
      tick(); idle();
      tick();
      chk("fl_empty", {26'd0, alu_op}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
